// File: rtl/data_mem_stage.sv
// MEM-stage byte-addressed data memory with range/funct3 trapping and sticky fault capture.
// Define MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of aligning them down.
module data_mem_stage #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_m,
  input  logic        mem_write_m,
  input  logic [2:0]  funct3_m,
  input  logic [31:0] alu_result_m,
  input  logic [31:0] write_data_m,
  output logic [31:0] read_data,
  output logic        mem_fault,
  output logic [31:0] fault_addr
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [7:0] mem [DEPTH];

  logic [1:0]  size_m1;
  logic        ld_ok;
  logic        st_ok;
  logic        misalign;
  logic        in_range;
  logic        illegal;
  logic        trap;
  logic [31:0] addr_a;
  logic [31:0] offset;
  logic [32:0] last;
  logic [31:0] word;

  logic [ADDR_WIDTH-1:0] idx0;
  logic [ADDR_WIDTH-1:0] idx1;
  logic [ADDR_WIDTH-1:0] idx2;
  logic [ADDR_WIDTH-1:0] idx3;

  always_comb begin
    size_m1 = 2'd0;
    ld_ok   = 1'b1;
    st_ok   = 1'b1;
    case (funct3_m)
      3'b000: size_m1 = 2'd0;
      3'b001: size_m1 = 2'd1;
      3'b010: size_m1 = 2'd3;
      3'b100: st_ok = 1'b0;
      3'b101: begin
        size_m1 = 2'd1;
        st_ok   = 1'b0;
      end
      default: begin
        ld_ok = 1'b0;
        st_ok = 1'b0;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign addr_a   = alu_result_m;
  assign misalign = |(alu_result_m[1:0] & size_m1);
`else
  // Sub-size address bits are dropped so the access lands aligned.
  assign addr_a   = alu_result_m & ~{30'b0, size_m1};
  assign misalign = 1'b0;
`endif

  assign offset   = addr_a - BASE_ADDR;
  assign last     = {1'b0, offset} + {31'b0, size_m1};
  assign in_range = last < 33'(DEPTH);
  assign illegal  = (mem_read_m & ~ld_ok) |
                    (mem_write_m & ~st_ok);
  assign trap     = (mem_read_m | mem_write_m) &
                    (~in_range | illegal | misalign);

  assign idx0 = offset[ADDR_WIDTH-1:0];
  assign idx1 = idx0 + ADDR_WIDTH'(1);
  assign idx2 = idx0 + ADDR_WIDTH'(2);
  assign idx3 = idx0 + ADDR_WIDTH'(3);

  assign word = {mem[idx3], mem[idx2],
                 mem[idx1], mem[idx0]};

  always_comb begin
    read_data = 32'h0;
    if (rst && mem_read_m && !trap) begin
      case (funct3_m)
        3'b000:  read_data = {{24{word[7]}}, word[7:0]};
        3'b001:  read_data = {{16{word[15]}}, word[15:0]};
        3'b010:  read_data = word;
        3'b100:  read_data = {24'h0, word[7:0]};
        3'b101:  read_data = {16'h0, word[15:0]};
        default: read_data = 32'h0;
      endcase
    end
  end

  // Array is deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (rst && mem_write_m && !trap) begin
      mem[idx0] <= write_data_m[7:0];
      if (size_m1 != 2'd0) begin
        mem[idx1] <= write_data_m[15:8];
      end
      if (size_m1 == 2'd3) begin
        mem[idx2] <= write_data_m[23:16];
        mem[idx3] <= write_data_m[31:24];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_fault  <= 1'b0;
      fault_addr <= 32'h0;
    end else if (trap && !mem_fault) begin
      mem_fault  <= 1'b1;
      fault_addr <= alu_result_m;
    end
  end

endmodule
